// File: rtl/seg_pkg.sv
// Shared constants, segment table and scan state type for the eight-digit display scanner.
// The leading-zero blank helper is used only when SEG_LEADING_ZERO_BLANK_EN is defined.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [7:0]  AN_OFF     = 8'hFF;

    // Active-low {G,F,E,D,C,B,A} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Marks zero digits above the most significant nonzero digit; digit 0 is never marked.
    function automatic logic [7:0] lz_blank_mask(input logic [31:0] d);
        logic [7:0] m;
        logic       seen;
        m    = 8'h00;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (d[i*4 +: 4] != 4'h0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            m[i] = ~seen;
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_controller_digit_anode_decode.sv
// Turns a digit index plus enable into the active-low anode word; disabled digits keep all anodes high.
module digit_anode_decode
    import seg_pkg::*;
(
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] an
);

    // One-cold decode of the selected digit.
    always_comb begin
        an = AN_OFF;
        if (en) begin
            an[idx] = 1'b0;
        end else begin
            an = AN_OFF;
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Eight-digit multiplexed seven-segment scanner with per-slot blanking and frame-aligned double buffering.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses segments of leading zero digits.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 12500,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        upd_pending,
    output logic        frame_start,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int unsigned      CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt_r;
    logic [2:0]       digit_idx_r;
    scan_state_e      state_r;
    scan_state_e      state_next_s;
    logic             slot_wrap_s;
    logic             frame_bnd_s;

    logic [31:0]      shadow_digits_r;
    logic [7:0]       shadow_dp_r;
    logic [31:0]      active_digits_r;
    logic [7:0]       active_dp_r;
    logic             upd_pending_r;

    logic [7:0]       an_dec_s;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    assign slot_wrap_s = (slot_cnt_r == SLOT_LAST);
    assign frame_bnd_s = slot_wrap_s && (digit_idx_r == 3'd7);

    // Slot counter and digit index; the index advances once per slot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_r  <= '0;
            digit_idx_r <= 3'd0;
        end else if (slot_wrap_s) begin
            slot_cnt_r  <= '0;
            digit_idx_r <= digit_idx_r + 3'd1;
        end else begin
            slot_cnt_r  <= slot_cnt_r + CNT_W'(1);
            digit_idx_r <= digit_idx_r;
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // DRIVE covers slot_cnt >= BLANK_CYCLES; every slot restarts in BLANK.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BLANK: begin
                if (slot_wrap_s) begin
                    state_next_s = BLANK;
                end else if (slot_cnt_r == BLANK_LAST) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = BLANK;
                end
            end
            DRIVE: begin
                if (slot_wrap_s) begin
                    state_next_s = BLANK;
                end else begin
                    state_next_s = DRIVE;
                end
            end
            default: state_next_s = BLANK;
        endcase
    end

    // Shadow/active buffers: a load on the boundary cycle stays pending for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits_r <= 32'h0000_0000;
            shadow_dp_r     <= 8'h00;
            active_digits_r <= 32'h0000_0000;
            active_dp_r     <= 8'h00;
            upd_pending_r   <= 1'b0;
        end else begin
            if (frame_bnd_s && upd_pending_r) begin
                active_digits_r <= shadow_digits_r;
                active_dp_r     <= shadow_dp_r;
            end else begin
                active_digits_r <= active_digits_r;
                active_dp_r     <= active_dp_r;
            end
            if (load) begin
                shadow_digits_r <= digits_in;
                shadow_dp_r     <= dp_in;
                upd_pending_r   <= 1'b1;
            end else if (frame_bnd_s) begin
                upd_pending_r   <= 1'b0;
            end else begin
                upd_pending_r   <= upd_pending_r;
            end
        end
    end

    digit_anode_decode u_anode_decode (
        .idx (digit_idx_r),
        .en  (digit_en[digit_idx_r]),
        .an  (an_dec_s)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] blank_mask_r;

    // Blank mask follows the digits that become active at each boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_mask_r <= lz_blank_mask(32'h0000_0000);
        end else if (frame_bnd_s && upd_pending_r) begin
            blank_mask_r <= lz_blank_mask(shadow_digits_r);
        end else begin
            blank_mask_r <= blank_mask_r;
        end
    end
`endif

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        nibble_s = active_digits_r[{digit_idx_r, 2'b00} +: 4];
        seg_s    = HEX_SEG[nibble_s];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (blank_mask_r[digit_idx_r]) begin
            seg_s = SEG_OFF;
        end else begin
            seg_s = HEX_SEG[nibble_s];
        end
`endif
    end

    // Registered pin drivers, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else if (state_r == BLANK) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_dec_s;
            seg_r <= seg_s;
            dp_r  <= ~active_dp_r[digit_idx_r];
        end
    end

    assign AN          = an_r;
    assign SEG         = seg_r;
    assign DP          = dp_r;
    assign upd_pending = upd_pending_r;
    assign frame_start = frame_bnd_s;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized self-checking bench for seg_scan_controller against a cycle-count based reference model.
// Honours SEG_LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seg_scan_controller;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] digits_in = 32'h0;
    logic [7:0]  dp_in = 8'h00;
    logic [7:0]  digit_en = 8'hFF;
    logic        load = 1'b0;
    logic        upd_pending;
    logic        frame_start;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    seg_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .load        (load),
        .upd_pending (upd_pending),
        .frame_start (frame_start),
        .AN          (AN),
        .SEG         (SEG),
        .DP          (DP)
    );

    always #5 clk = ~clk;

    logic [6:0] hexs [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since reset; slot and digit follow from it arithmetically.
    int          m_t = 0;
    bit          m_started = 1'b0;
    logic [31:0] m_sh = 32'h0, m_act = 32'h0;
    logic [7:0]  m_sh_dp = 8'h0, m_act_dp = 8'h0;
    logic        m_pend = 1'b0;
    logic [7:0]  e_an = 8'hFF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    always @(posedge clk) begin
        int slot, idx, msd;
        m_started = 1'b1;
        if (reset) begin
            m_t = 0; m_sh = 32'h0; m_act = 32'h0; m_sh_dp = 8'h0; m_act_dp = 8'h0;
            m_pend = 1'b0; e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            slot = m_t % RD;
            idx  = (m_t / RD) % 8;
            if (slot < BC) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = digit_en[idx] ? ~(8'h01 << idx) : 8'hFF;
                e_seg = hexs[m_act[idx*4 +: 4]];
                msd = 0;
                for (int i = 0; i < 8; i++)
                    if (m_act[i*4 +: 4] != 4'h0) msd = i;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (idx > msd) e_seg = 7'h7F;
`endif
                e_dp = ~m_act_dp[idx];
            end
            if (slot == RD - 1 && idx == 7 && m_pend) begin
                m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
            end
            if (load) begin
                m_sh = digits_in; m_sh_dp = dp_in; m_pend = 1'b1;
            end
            m_t++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_started) begin
            check("frame_start", frame_start, ((m_t % RD) == RD - 1) && (((m_t / RD) % 8) == 7));
            check("upd_pending", upd_pending, m_pend);
            check("AN", AN, e_an);
            check("SEG", SEG, e_seg);
            check("DP", DP, e_dp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] p);
        digits_in = d; dp_in = p; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [7:0] v, input string nm);
        int k = 0;
        while (AN !== v && k < 200) begin cyc(1); k++; end
        check({nm, "_timeout"}, (k < 200), 1'b1);
    endtask

    task automatic wait_fs(input string nm);
        int k = 0;
        do begin cyc(1); k++; end while (!frame_start && k < 200);
        check({nm, "_timeout"}, (k < 200), 1'b1);
    endtask

    task automatic frame_period(input string nm);
        int k = 0;
        wait_fs(nm);
        do begin cyc(1); k++; end while (!frame_start && k < 200);
        check(nm, k, 64);
    endtask

    initial begin
        logic [6:0] seen [8];
        int bad_an, bad_dp, dp_lo;

        // Reset and idle state.
        cyc(3);
        reset = 1'b0;
        check("rst_AN", AN, 8'hFF);
        check("rst_SEG", SEG, 7'h7F);
        check("rst_DP", DP, 1'b1);
        check("rst_pend", upd_pending, 1'b0);

        // Scan sequence with 76543210.
        pulse_load(32'h76543210, 8'h00);
        check("load_pend", upd_pending, 1'b1);
        wait_fs("fs1");
        cyc(1);
        check("pend_clear", upd_pending, 1'b0);
        wait_an(8'hFD, "dig1");
        check("dig1_seg", SEG, 7'b1111001);
        frame_period("period_full");

        // Mid-frame load while digit 3 is scanned.
        wait_an(8'hF7, "dig3");
        pulse_load(32'hFFFFFFFF, 8'h00);
        wait_an(8'hEF, "dig4_old");
        check("dig4_old_seg", SEG, 7'b0011001);
        check("mid_pend", upd_pending, 1'b1);
        wait_fs("fs_mid");
        check("fs_pend", upd_pending, 1'b1);
        cyc(1);
        check("fs_pend_clr", upd_pending, 1'b0);
        wait_an(8'hFE, "dig0_new");
        check("dig0_F", SEG, 7'b0001110);

        // Two loads in one frame: the second wins.
        wait_fs("fs_two");
        cyc(5);
        pulse_load(32'h00000001, 8'h00);
        cyc(5);
        pulse_load(32'h00000002, 8'h00);
        wait_fs("fs_two_b");
        wait_an(8'hFE, "dig0_two");
        check("two_loads", SEG, 7'b0100100);

        // Load on the boundary cycle is deferred a full frame.
        wait_fs("fs_coll");
        pulse_load(32'h00000003, 8'h00);
        check("coll_pend", upd_pending, 1'b1);
        wait_an(8'hFE, "dig0_coll");
        check("coll_old", SEG, 7'b0100100);
        wait_fs("fs_coll_b");
        wait_an(8'hFE, "dig0_coll_b");
        check("coll_new", SEG, 7'b0110000);

        // Enable mask with decimal point on digit 0.
        digit_en = 8'h0F;
        pulse_load(32'h76543210, 8'h01);
        wait_fs("fs_en");
        bad_an = 0; bad_dp = 0; dp_lo = 0;
        for (int c = 0; c < 128; c++) begin
            cyc(1);
            if (AN[7:4] != 4'hF) bad_an++;
            if (DP == 1'b0 && AN != 8'hFE) bad_dp++;
            if (DP == 1'b0) dp_lo++;
        end
        check("en_an_hi", bad_an, 0);
        check("en_dp_only0", bad_dp, 0);
        check("en_dp_lit", dp_lo, 12);
        frame_period("period_masked");

        // Leading-zero behaviour with 00000A05.
        digit_en = 8'hFF;
        pulse_load(32'h00000A05, 8'h00);
        wait_fs("fs_lz");
        for (int i = 0; i < 8; i++) seen[i] = 7'h00;
        for (int c = 0; c < 64; c++) begin
            cyc(1);
            for (int i = 0; i < 8; i++)
                if (AN == ~(8'h01 << i)) seen[i] = SEG;
        end
        for (int i = 3; i < 8; i++) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
            check($sformatf("lz_dig%0d", i), seen[i], 7'h7F);
`else
            check($sformatf("lz_dig%0d", i), seen[i], 7'b1000000);
`endif
        end
        check("lz_dig2", seen[2], 7'b0001000);
        check("lz_dig1", seen[1], 7'b1000000);
        check("lz_dig0", seen[0], 7'b0010010);

        // Randomized loads, masks and occasional resets.
        for (int c = 0; c < 2500; c++) begin
            load = ($urandom_range(0, 39) == 0);
            digits_in = $urandom;
            dp_in = 8'($urandom);
            if ($urandom_range(0, 199) == 0) digit_en = 8'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        load = 1'b0; reset = 1'b0;
        cyc(2);

        // Reset held three cycles mid-drive with data pending.
        digit_en = 8'hFF;
        pulse_load(32'h89ABCDEF, 8'hFF);
        wait_an(8'hFB, "pre_rst");
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            check("mr_AN", AN, 8'hFF);
            check("mr_SEG", SEG, 7'h7F);
            check("mr_DP", DP, 1'b1);
            check("mr_pend", upd_pending, 1'b0);
        end
        reset = 1'b0;
        begin
            logic [7:0] first_an;
            int k;
            k = 0;
            first_an = 8'hFF;
            while (first_an == 8'hFF && k < 100) begin cyc(1); k++; first_an = AN; end
            check("restart_dig0", first_an, 8'hFE);
            check("restart_seg", SEG, 7'b1000000);
            check("restart_dp", DP, 1'b1);
        end
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
